// File: rtl/cond_sub_pkg.sv
// ============================================================================
// Module      : cond_sub_pkg
// Description : Shared geometry, index width and FSM state encoding for the
//               block-serial conditional subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cond_sub_pkg;

    localparam int BLOCK   = 128;
    localparam int NUM_BLK = 25;
    localparam int WIDTH   = BLOCK * NUM_BLK;
    localparam int IDX_W   = $clog2(NUM_BLK);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_SEL  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/unit_subtractor.sv
// ============================================================================
// Module      : unit_subtractor
// Description : One BLOCK-bit slice of a ripple subtraction: a - b - bin,
//               returning the slice difference and the borrow-out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unit_subtractor #(
    parameter int BLOCK = cond_sub_pkg::BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             bin,
    output logic [BLOCK-1:0] diff,
    output logic             bout
);
    import cond_sub_pkg::*;

    // One extra bit catches the wrap when the slice result goes negative.
    logic [BLOCK:0] w_full;

    assign w_full = {1'b0, a} - {1'b0, b} - {{BLOCK{1'b0}}, bin};
    assign diff   = w_full[BLOCK-1:0];
    assign bout   = w_full[BLOCK];

endmodule

`default_nettype wire

// File: rtl/cond_sub_3200_128.sv
// ============================================================================
// Module      : cond_sub_3200_128
// Description : Block-serial conditional subtractor. Computes sum - M one
//               BLOCK-bit slice per cycle through a single shared subtractor,
//               then selects either the difference or the original sum.
//               Optional status output "reduced" exists only when the macro
//               COND_SUB_STATUS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_sub_3200_128 #(
    parameter int BLOCK   = cond_sub_pkg::BLOCK,
    parameter int NUM_BLK = cond_sub_pkg::NUM_BLK,
    parameter int WIDTH   = BLOCK * NUM_BLK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] sum,
    input  logic             sum_cout,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] res,
    output logic             en_out,
    output logic             busy
`ifdef COND_SUB_STATUS_EN
    ,
    output logic             reduced
`endif
);
    import cond_sub_pkg::*;

    localparam int                 c_IDX_W  = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
    localparam logic [c_IDX_W-1:0] c_K_LAST = c_IDX_W'(NUM_BLK - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_IDX_W-1:0] r_k;
    logic               r_borrow;
    logic               r_cout;
    logic [WIDTH-1:0]   r_sum;
    logic [WIDTH-1:0]   r_mod;
    logic [WIDTH-1:0]   r_diff;

    logic               w_capture;
    logic               w_step;
    logic               w_sel;
    logic               w_last;
    logic               w_reduce;
    logic [BLOCK-1:0]   w_blk_diff;
    logic               w_blk_bout;

    // Captured operands rotate/shift so the active slice always sits in the
    // low BLOCK bits; this avoids a wide variable-index mux.
    unit_subtractor #(
        .BLOCK (BLOCK)
    ) u_unit_subtractor (
        .a    (r_sum[BLOCK-1:0]),
        .b    (r_mod[BLOCK-1:0]),
        .bin  (r_borrow),
        .diff (w_blk_diff),
        .bout (w_blk_bout)
    );

    assign w_last   = (r_k == c_K_LAST);
    // A carry above the top bit means the true sum already exceeds M.
    assign w_reduce = r_cout | ~r_borrow;
    // En_out cycle is already IDLE but still counts as busy.
    assign busy     = (r_state != ST_IDLE) | en_out;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_step      = 1'b0;
        w_sel       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_SUB;
                end
            end
            ST_SUB: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_SEL;
                end
            end
            ST_SEL: begin
                w_sel       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Slice counter, borrow chain, result register and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k      <= '0;
            r_borrow <= 1'b0;
            r_cout   <= 1'b0;
            res      <= '0;
            en_out   <= 1'b0;
        end else begin
            en_out <= w_sel;
            if (w_capture) begin
                r_k      <= '0;
                r_borrow <= 1'b0;
                r_cout   <= sum_cout;
            end else if (w_step) begin
                r_borrow <= w_blk_bout;
                r_k      <= w_last ? '0 : r_k + c_IDX_W'(1);
            end
            if (w_sel) begin
                res <= w_reduce ? r_diff : r_sum;
            end
        end
    end

    // Wide operand/difference storage; after NUM_BLK rotations r_sum is back
    // in its original order and r_diff holds the full difference.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_sum <= sum;
            r_mod <= modulus;
        end else if (w_step) begin
            r_sum  <= {r_sum[BLOCK-1:0], r_sum[WIDTH-1:BLOCK]};
            r_mod  <= {{BLOCK{1'b0}}, r_mod[WIDTH-1:BLOCK]};
            r_diff <= {w_blk_diff, r_diff[WIDTH-1:BLOCK]};
        end
    end

`ifdef COND_SUB_STATUS_EN
    // Status flag registered alongside res.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reduced <= 1'b0;
        end else if (w_sel) begin
            reduced <= w_reduce;
        end
    end
`endif

endmodule

`default_nettype wire
